traceback_unit: RTL
===================

TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 Parameter TB_DEPTH, default 16, is the traceback window length in trellis steps, legal range 4..64.
REQ-002 Parameter NUM_ST, default 256, is the trellis state count; the state width is 8 bits, fixed.
REQ-003 clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  is the reset, asynchronous and active-high.
REQ-005 en_tb  input  1  qualifies one survivor column on i_fwd_nxt_st this cycle.
REQ-006 i_fwd_nxt_st  input  8 x NUM_ST (unpacked [255:0])  gives the selected predecessor state per state, from add_compare_select.
REQ-007 i_sel_node  input  8  is the minimum-metric state; it is sampled only with the TB_DEPTH-th column.
REQ-008 o_ready  output  1  is high when a column is accepted this cycle (IDLE or WRITE).
REQ-009 o_bit  output  1  carries the decoded information bit.
REQ-010 o_valid  output  1  qualifies o_bit.
REQ-011 o_last  output  1  is high with the final bit of a window.
REQ-012 o_ovf  output  1  is a sticky flag: a column arrived while o_ready was low.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, TRACE and OUTPUT.
REQ-014 The block SHALL move IDLE->WRITE on the first accepted column, storing it at column 0.
REQ-015 In WRITE, each accepted column SHALL be stored at column index wcnt, and wcnt SHALL increment.
REQ-016 Cycles without en_tb SHALL hold all state.
REQ-017 When column TB_DEPTH-1 is accepted, the block SHALL capture i_sel_node into ptr, clear wcnt and enter TRACE on the next cycle.
REQ-018 TRACE SHALL take exactly TB_DEPTH cycles, with k running from TB_DEPTH-1 down to 0.
REQ-019 Each TRACE cycle SHALL set decoded bit[k] = ptr[7] and ptr <= mem[k][ptr].
REQ-020 After TRACE, the block SHALL enter OUTPUT, or return to IDLE when reordering is compiled out (REQ-031).
REQ-021 OUTPUT SHALL emit bit[0]..bit[TB_DEPTH-1] on consecutive cycles with o_valid=1, then return to IDLE.
REQ-022 o_last SHALL be high on the final valid bit of each window.
REQ-023 o_ready SHALL be 1 in IDLE and WRITE and 0 in TRACE and OUTPUT.
REQ-024 en_tb with o_ready=0 SHALL discard the column, leave memory unchanged and set o_ovf.
REQ-025 With reordering, latency SHALL be TB_DEPTH+1 cycles from acceptance of the last column to the first o_valid.
REQ-026 wcnt SHALL wrap from TB_DEPTH-1 to 0.
REQ-027 No backpressure SHALL exist on the output; a consumer must accept one bit per cycle.

Reset
REQ-028 On rst, asynchronously: state=IDLE, wcnt=0, ptr=0, o_bit=0, o_valid=0, o_last=0, o_ovf=0, o_ready=1.
REQ-029 Survivor memory and the bit buffer SHALL not be reset; their contents after reset are don't-care.
REQ-030 rst mid-TRACE or mid-OUTPUT SHALL abort the window; no further o_valid SHALL occur until a new full window is written.

Configuration
REQ-031 Macro TB_REORDER_EN, when defined, SHALL enable the bit buffer and OUTPUT state, giving oldest-first output.
REQ-032 When TB_REORDER_EN is undefined, bit[k] SHALL be driven on o_bit with o_valid=1 during each TRACE cycle, newest-first.
REQ-033 When TB_REORDER_EN is undefined, o_last SHALL coincide with k=0, latency SHALL be 1 cycle, and the OUTPUT state and buffer SHALL be absent.

Structure
REQ-034 NUM_ST, the state width (8), the default TB_DEPTH and the FSM state enum SHALL live in the shared package viterbi_pkg, alongside MAX_TRANSITION_NUM.
REQ-035 The survivor store SHALL be one sub-module, survivor_mem: TB_DEPTH x NUM_ST x 8 bits, one column write port and one asynchronous single-entry read port (k, ptr).

Verification
REQ-036 Reset then all-zero columns x16, sel_node=0x00 -> 16 valid bits all 0, o_last on the 16th, first o_valid 17 cycles after the last column.
REQ-037 Columns with mem[k][s]=s<<1|1, sel_node=0xFF -> all 16 bits equal 1; ptr stays 0xFF throughout.
REQ-038 Encoded 16-bit pattern 0xA5C3 through a reference model, TB_REORDER_EN defined -> o_bit stream equals 1010_0101_1100_0011 oldest-first.
REQ-039 en_tb held high for 20 cycles -> columns 17..20 are dropped, o_ovf=1 and sticky, and the window still decodes correctly.
REQ-040 rst asserted at the 5th TRACE cycle -> outputs clear immediately; no o_valid until a new 16 columns arrive.
REQ-041 Same stimulus as REQ-038 without TB_REORDER_EN -> bits arrive reversed, first o_valid 1 cycle after the last column, o_last with the 16th bit.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: trellis geometry, traceback defaults and
// the traceback FSM state encoding.
package viterbi_pkg;

  localparam int NUM_ST             = 256;
  localparam int ST_W               = 8;
  localparam int TB_DEPTH_DEF       = 16;
  localparam int MAX_TRANSITION_NUM = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    TRACE  = 2'd2,
    OUTPUT = 2'd3
  } tb_state_e;

endpackage

// File: rtl/survivor_mem.sv
// Survivor store: TB_DEPTH columns of NUM_ST predecessor states, whole-column
// write and a single asynchronous (column, state) read.
module survivor_mem
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int NUM_ST   = viterbi_pkg::NUM_ST,
  localparam int AW      = $clog2(TB_DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ST_W-1:0] wdata [NUM_ST-1:0],
  input  logic [AW-1:0]   rk,
  input  logic [ST_W-1:0] rptr,
  output logic [ST_W-1:0] rdata
);

  logic [ST_W-1:0] mem_r [TB_DEPTH-1:0][NUM_ST-1:0];

  // Column write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int s = 0; s < NUM_ST; s++) begin
        mem_r[waddr][s] <= wdata[s];
      end
    end
  end

  assign rdata = mem_r[rk][rptr];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: collects TB_DEPTH survivor columns, traces back from the
// selected node and emits decoded bits. TB_REORDER_EN adds oldest-first output.
module traceback_unit
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int NUM_ST   = viterbi_pkg::NUM_ST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_tb,
  input  logic [ST_W-1:0] i_fwd_nxt_st [NUM_ST-1:0],
  input  logic [ST_W-1:0] i_sel_node,
  output logic            o_ready,
  output logic            o_bit,
  output logic            o_valid,
  output logic            o_last,
  output logic            o_ovf
);

  localparam int AW = $clog2(TB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_COL = AW'(TB_DEPTH - 1);

  tb_state_e       state_r;
  logic [AW-1:0]   wcnt_r;
  logic [CW-1:0]   cnt_r;
  logic [ST_W-1:0] ptr_r;
  logic [ST_W-1:0] pred_s;
  logic            accept_s;

  assign accept_s = en_tb & o_ready;

  survivor_mem #(
    .TB_DEPTH (TB_DEPTH),
    .NUM_ST   (NUM_ST)
  ) u_mem (
    .clk   (clk),
    .we    (accept_s),
    .waddr (wcnt_r),
    .wdata (i_fwd_nxt_st),
    .rk    (cnt_r[AW-1:0]),
    .rptr  (ptr_r),
    .rdata (pred_s)
  );

`ifdef TB_REORDER_EN
  logic [TB_DEPTH-1:0] bitbuf_r;

  // Decoded bits land at their trellis index so OUTPUT can replay oldest-first
  always_ff @(posedge clk) begin
    if (state_r == TRACE) begin
      bitbuf_r[cnt_r[AW-1:0]] <= ptr_r[ST_W-1];
    end
  end
`endif

  // Window FSM: column capture, traceback walk and registered bit output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      wcnt_r  <= '0;
      cnt_r   <= '0;
      ptr_r   <= '0;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_ovf   <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      if (en_tb && !o_ready) begin
        o_ovf <= 1'b1;
      end
      case (state_r)
        IDLE, WRITE: begin
          if (accept_s) begin
            if (wcnt_r == LAST_COL) begin
              wcnt_r  <= '0;
              ptr_r   <= i_sel_node;
              cnt_r   <= CW'(TB_DEPTH - 1);
              state_r <= TRACE;
              o_ready <= 1'b0;
`ifndef TB_REORDER_EN
              // Newest bit is the MSB of the start node, visible in the first TRACE cycle
              o_bit   <= i_sel_node[ST_W-1];
              o_valid <= 1'b1;
              o_last  <= 1'b0;
`endif
            end else begin
              wcnt_r  <= wcnt_r + AW'(1);
              state_r <= WRITE;
            end
          end
        end
        TRACE: begin
          ptr_r <= pred_s;
          if (cnt_r == '0) begin
`ifdef TB_REORDER_EN
            state_r <= OUTPUT;
            o_bit   <= ptr_r[ST_W-1];
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            cnt_r   <= CW'(1);
`else
            state_r <= IDLE;
            o_bit   <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_ready <= 1'b1;
`endif
          end else begin
            cnt_r <= cnt_r - CW'(1);
`ifndef TB_REORDER_EN
            o_bit  <= pred_s[ST_W-1];
            o_last <= (cnt_r == CW'(1));
`endif
          end
        end
        OUTPUT: begin
`ifdef TB_REORDER_EN
          if (cnt_r == CW'(TB_DEPTH)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            o_bit   <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_ready <= 1'b1;
          end else begin
            o_bit  <= bitbuf_r[cnt_r[AW-1:0]];
            o_last <= (cnt_r == CW'(TB_DEPTH - 1));
            cnt_r  <= cnt_r + CW'(1);
          end
`else
          state_r <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
`endif
        end
        default: begin
          state_r <= IDLE;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
